// File: rtl/count_limit_monitor.sv
// count_limit_monitor: enable/load up-counter with an immediate (trigger-gated) and a
// next-cycle range check of count < LIMIT, failure accounting and a halt-on-fail FSM.
module count_limit_monitor #(
    parameter int WIDTH        = 4,
    parameter int LIMIT        = 10,
    parameter int MODE         = 0,
    parameter int HALT_ON_FAIL = 1,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             trigger,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             imm_pass,
    output logic             imm_fail,
    output logic             seq_pass,
    output logic             seq_fail,
    output logic             fail_sticky,
    output logic [ERR_W-1:0] fail_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // One extra bit so that LIMIT = 2**WIDTH is representable and every check passes.
    localparam logic [WIDTH:0] LIM    = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0] LIM_M1 = (WIDTH+1)'(LIMIT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             pend;
    logic             run;
    logic             cur_ok;
    logic             imm_pass_d;
    logic             imm_fail_d;
    logic             seq_pass_d;
    logic             seq_fail_d;
    logic [1:0]       n_fail;
    logic [WIDTH-1:0] count_d;

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < LIM);
    endfunction

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                  input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, a} + (ERR_W+1)'(inc);
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        logic             at_top;
        logic [WIDTH-1:0] nxt;
        at_top = ({1'b0, v} >= LIM_M1);
        nxt    = v + WIDTH'(1);
        if (MODE == 2)
            return nxt;
        else if (MODE == 1)
            return at_top ? v : nxt;
        else
            return at_top ? '0 : nxt;
    endfunction

    // Decide: check results, FSM next state and next count from pre-edge values
    always_comb begin
        run        = (state_q == RUN);
        cur_ok     = in_range(count);
        imm_pass_d = run && trigger && cur_ok;
        imm_fail_d = run && trigger && !cur_ok;
        seq_pass_d = pend && cur_ok;
        seq_fail_d = pend && !cur_ok;
        n_fail     = {1'b0, imm_fail_d} + {1'b0, seq_fail_d};

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if ((HALT_ON_FAIL != 0) && (n_fail != 2'd0)) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;

        count_d = count;
        if (run) begin
            if (load)
                count_d = load_val;
            else if (en)
                count_d = advance(count);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Register: counter, pending next-cycle check, result pulses and failure accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            pend        <= 1'b0;
            imm_pass    <= 1'b0;
            imm_fail    <= 1'b0;
            seq_pass    <= 1'b0;
            seq_fail    <= 1'b0;
            fail_sticky <= 1'b0;
            fail_count  <= '0;
        end else if (clear) begin
            // A pending check is dropped; the counter value itself is kept.
            pend        <= 1'b0;
            imm_pass    <= 1'b0;
            imm_fail    <= 1'b0;
            seq_pass    <= 1'b0;
            seq_fail    <= 1'b0;
            fail_sticky <= 1'b0;
            fail_count  <= '0;
        end else begin
            count      <= count_d;
            pend       <= run && (en || load);
            imm_pass   <= imm_pass_d;
            imm_fail   <= imm_fail_d;
            seq_pass   <= seq_pass_d;
            seq_fail   <= seq_fail_d;
            fail_count <= sat_add(fail_count, n_fail);
            if (n_fail != 2'd0)
                fail_sticky <= 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_count_limit_monitor.sv
// Bench for count_limit_monitor: four parameterisations share one stimulus stream and
// are compared every cycle against a behavioural model, plus a vector table and corner sequences.
module tb_count_limit_monitor;
    localparam int NI = 4;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, en, load, trigger, clear;
    logic [W-1:0] load_val;

    logic [W-1:0] count       [NI];
    logic         imm_pass    [NI];
    logic         imm_fail    [NI];
    logic         seq_pass    [NI];
    logic         seq_fail    [NI];
    logic         fail_sticky [NI];
    logic [7:0]   fcnt        [NI];
    logic [1:0]   state       [NI];

    always #5 clk = ~clk;

    // 0: LIMIT10 wrap halt; 1: saturate, no halt, ERR_W=2; 2: free-run, no halt; 3: LIMIT=2^W
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LIM = (g == 3) ? 16 : 10;
        localparam int MD  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int HLT = (g == 1 || g == 2) ? 0 : 1;
        localparam int EW  = (g == 1) ? 2 : 8;
        logic [EW-1:0] fc;
        count_limit_monitor #(
            .WIDTH(W), .LIMIT(LIM), .MODE(MD), .HALT_ON_FAIL(HLT), .ERR_W(EW)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start), .en(en), .load(load),
            .load_val(load_val), .trigger(trigger), .clear(clear),
            .count(count[g]), .imm_pass(imm_pass[g]), .imm_fail(imm_fail[g]),
            .seq_pass(seq_pass[g]), .seq_fail(seq_fail[g]),
            .fail_sticky(fail_sticky[g]), .fail_count(fc), .state(state[g])
        );
        assign fcnt[g] = 8'(fc);
    end

    int checks = 0;
    int errors = 0;

    int m_lim  [NI];
    int m_mode [NI];
    int m_halt [NI];
    int m_ew   [NI];
    int m_st   [NI];
    int m_cnt  [NI];
    int m_fc   [NI];
    bit m_pend [NI];
    bit m_ip   [NI];
    bit m_if   [NI];
    bit m_sp   [NI];
    bit m_sf   [NI];
    bit m_stk  [NI];

    typedef struct {
        bit         s, e, l;
        logic [3:0] lv;
        bit         t, c;
        int         e_cnt, e_st;
        bit         e_ip, e_if, e_sp, e_sf;
        int         e_fc;
        bit         e_stk;
    } vec_t;
    vec_t vt[14];

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_fc[i] = 0; m_pend[i] = 0;
            m_ip[i] = 0; m_if[i] = 0; m_sp[i] = 0; m_sf[i] = 0; m_stk[i] = 0;
        end
    endtask

    task automatic model_step();
        bit run;
        bit ok;
        int nf;
        int fmax;
        for (int i = 0; i < NI; i++) begin
            if (clear) begin
                m_st[i] = 0; m_pend[i] = 0; m_fc[i] = 0; m_stk[i] = 0;
                m_ip[i] = 0; m_if[i] = 0; m_sp[i] = 0; m_sf[i] = 0;
            end else begin
                run     = (m_st[i] == 1);
                ok      = (m_cnt[i] < m_lim[i]);
                m_ip[i] = run && trigger && ok;
                m_if[i] = run && trigger && !ok;
                m_sp[i] = m_pend[i] && ok;
                m_sf[i] = m_pend[i] && !ok;
                nf      = int'(m_if[i]) + int'(m_sf[i]);
                fmax    = (1 << m_ew[i]) - 1;
                m_fc[i] = (m_fc[i] + nf > fmax) ? fmax : m_fc[i] + nf;
                if (nf > 0) m_stk[i] = 1;
                if (run) begin
                    if (load)
                        m_cnt[i] = int'(load_val);
                    else if (en) begin
                        case (m_mode[i])
                            0:       m_cnt[i] = (m_cnt[i] >= m_lim[i] - 1) ? 0 : m_cnt[i] + 1;
                            1:       m_cnt[i] = (m_cnt[i] >= m_lim[i] - 1) ? m_cnt[i] : m_cnt[i] + 1;
                            default: m_cnt[i] = (m_cnt[i] + 1) % 16;
                        endcase
                    end
                end
                if (m_st[i] == 0 && start)
                    m_st[i] = 1;
                else if (m_st[i] == 1 && m_halt[i] != 0 && nf > 0)
                    m_st[i] = 2;
                m_pend[i] = run && (en || load);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check("count", i, count[i], m_cnt[i]);
            check("state", i, state[i], m_st[i]);
            check("imm_pass", i, imm_pass[i], m_ip[i]);
            check("imm_fail", i, imm_fail[i], m_if[i]);
            check("seq_pass", i, seq_pass[i], m_sp[i]);
            check("seq_fail", i, seq_fail[i], m_sf[i]);
            check("fail_sticky", i, fail_sticky[i], m_stk[i]);
            check("fail_count", i, fcnt[i], m_fc[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit s, input bit e, input bit l, input logic [3:0] lv,
                          input bit t, input bit c);
        start = s; en = e; load = l; load_val = lv; trigger = t; clear = c;
    endtask

    // Called just after a tick: reset rises mid-cycle and is released on the falling edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_count", 0, count[0], 0);
        check("rst_state", 0, state[0], 0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        m_lim  = '{10, 10, 10, 16};
        m_mode = '{0, 1, 2, 0};
        m_halt = '{1, 0, 0, 1};
        m_ew   = '{8, 2, 8, 8};

        // s  e  l  lv  t  c | cnt st ip if sp sf fc stk   (expectations for instance 0)
        vt[0]  = '{1, 0, 0, 4'd0,  0, 0,  0, 1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 4'd0,  1, 0,  1, 1, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 4'd0,  0, 0,  2, 1, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 1, 1, 4'd7,  0, 0,  7, 1, 0, 0, 1, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 4'd0,  1, 0,  7, 1, 1, 0, 1, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 4'd0,  0, 0,  7, 1, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 4'd12, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 4'd0,  1, 0, 12, 2, 0, 1, 0, 1, 2, 1};
        vt[8]  = '{0, 1, 0, 4'd0,  1, 0, 12, 2, 0, 0, 0, 0, 2, 1};
        vt[9]  = '{0, 0, 0, 4'd0,  0, 1, 12, 0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{0, 1, 1, 4'd3,  1, 0, 12, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{1, 0, 0, 4'd0,  0, 0, 12, 1, 0, 0, 0, 0, 0, 0};
        vt[12] = '{0, 0, 1, 4'd13, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 0, 0, 4'd0,  1, 1, 13, 0, 0, 0, 0, 0, 0, 0};

        reset = 1'b1;
        set_in(0, 0, 0, 4'd0, 0, 0);
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            set_in(vt[k].s, vt[k].e, vt[k].l, vt[k].lv, vt[k].t, vt[k].c);
            tick();
            check("tv_count", k, count[0], vt[k].e_cnt);
            check("tv_state", k, state[0], vt[k].e_st);
            check("tv_imm_pass", k, imm_pass[0], vt[k].e_ip);
            check("tv_imm_fail", k, imm_fail[0], vt[k].e_if);
            check("tv_seq_pass", k, seq_pass[0], vt[k].e_sp);
            check("tv_seq_fail", k, seq_fail[0], vt[k].e_sf);
            check("tv_fail_count", k, fcnt[0], vt[k].e_fc);
            check("tv_sticky", k, fail_sticky[0], vt[k].e_stk);
        end

        // Wrap with trigger held: 0..9,0..9,0..4 and every check passes.
        async_reset();
        set_in(1, 0, 0, 4'd0, 0, 0);
        tick();
        for (int k = 1; k <= 25; k++) begin
            set_in(0, 1, 0, 4'd0, 1, 0);
            tick();
            check("wrap_count", k, count[0], k % 10);
            check("wrap_imm_pass", k, imm_pass[0], 1);
            check("wrap_seq_pass", k, seq_pass[0], (k >= 2) ? 1 : 0);
            check("pow2_count", k, count[3], k % 16);
        end
        check("wrap_fail_count", 0, fcnt[0], 0);
        check("pow2_fail_count", 3, fcnt[3], 0);

        // Saturate at 9 versus free-run overrun.
        async_reset();
        set_in(1, 0, 0, 4'd0, 0, 0);
        tick();
        for (int k = 1; k <= 17; k++) begin
            set_in(0, 1, 0, 4'd0, 0, 0);
            tick();
            if (k == 10 || k == 11)
                check("overrun_seq_fail", k, seq_fail[2], (k == 11) ? 1 : 0);
        end
        check("sat_count", 1, count[1], 9);
        check("sat_fail_count", 1, fcnt[1], 0);
        check("free_count", 2, count[2], 1);
        check("free_fail_count", 2, fcnt[2], 6);
        check("free_sticky", 2, fail_sticky[2], 1);
        check("wrap17_count", 0, count[0], 7);

        // Repeated out-of-range load: ERR_W=2 counter stops at 3.
        async_reset();
        set_in(1, 0, 0, 4'd0, 0, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            set_in(0, 1, 1, 4'd12, 1, 0);
            tick();
        end
        check("errsat_fail_count", 1, fcnt[1], 3);
        check("err8_fail_count", 2, fcnt[2], 6);
        check("halt_state", 0, state[0], 2);

        // Randomised traffic with occasional asynchronous reset.
        async_reset();
        for (int k = 0; k < 2000; k++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
            tick();
            if ($urandom_range(0, 199) == 0)
                async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
